uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter peripheral. It is the bus responder for the data-memory store/load accesses that the single-cycle core's control path issues (MemWrite/MemRead with the ALU-computed address on HADDR).
- CPU stores push bytes into a small TX FIFO.
- A baud-paced FSM serialises each byte as 8N1 on the tx pin.
- Loads return status and the baud divisor combinationally, so LW completes within the core's single cycle.

---
 rtl/uart_mmio_pkg.sv | 22 ++
 rtl/uart_tx_fifo.sv | 51 +++++
 rtl/uart_tx_mmio.sv | 147 ++++++++++++++
 tb/tb_uart_tx_mmio.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - register map, status bits and TX FSM encoding for uart_tx_mmio
package uart_mmio_pkg;
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;

    localparam int ST_BUSY   = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_EMPTY  = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 4;

    localparam int          FRAME_BITS = 10;
    localparam logic [15:0] MIN_DIV    = 16'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous FIFO with head data-out; a push is accepted when full only if a pop coincides
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign full   = count == FULL_CNT;
    assign empty  = count == '0;
    assign dout   = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= din;
                wrPtr      <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter: bus decode, registers and baud-paced TX FSM
module uart_tx_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter logic [15:0] DEFAULT_DIV = 16'd434,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] HRDATA,
    output logic        tx,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          hit;
    logic [1:0]    offset;
    logic          wrTxData;
    logic          wrStatus;
    logic          wrBaud;
    logic          fifoPop;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [7:0]    fifoHead;
    logic [CW-1:0] fifoCount;
    logic [15:0]   baudDiv;
    logic [15:0]   shadowDiv;
    logic [15:0]   baudCnt;
    logic          overflow;
    logic          bitDone;
    txState_t      state;
    logic [7:0]    shiftReg;
    logic [2:0]    bitIdx;
    logic [31:0]   statusWord;
    logic          unusedBits;

    assign hit      = HADDR[31:4] == BASE_ADDR[31:4];
    assign offset   = HADDR[3:2];
    assign wrTxData = MemWrite && hit && (offset == OFF_TXDATA);
    assign wrStatus = MemWrite && hit && (offset == OFF_STATUS);
    assign wrBaud   = MemWrite && hit && (offset == OFF_BAUD);
    assign bitDone  = baudCnt == 16'd0;
    // The FSM only consumes a byte when idle or at the end of a stop bit
    assign fifoPop  = !fifoEmpty && ((state == IDLE) || ((state == STOP) && bitDone));
    assign unusedBits = ^{HADDR[1:0], HWDATA[31:16]};

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wrTxData),
        .pop   (fifoPop),
        .din   (HWDATA[7:0]),
        .dout  (fifoHead),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    always_comb begin
        statusWord                    = '0;
        statusWord[ST_BUSY]           = state != IDLE;
        statusWord[ST_FULL]           = fifoFull;
        statusWord[ST_EMPTY]          = fifoEmpty;
        statusWord[ST_OVF]            = overflow;
        statusWord[ST_CNT_LO +: 3]    = 3'(fifoCount);
    end

    always_comb begin
        HRDATA = '0;
        if (MemRead && hit) begin
            case (offset)
                OFF_STATUS: HRDATA = statusWord;
                OFF_BAUD:   HRDATA = {16'h0, baudDiv};
                default:    HRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baudDiv  <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else begin
            if (wrBaud) begin
                baudDiv <= (HWDATA[15:0] < MIN_DIV) ? MIN_DIV : HWDATA[15:0];
            end
            // A dropped push outranks a simultaneous clear
            if (wrTxData && fifoFull && !fifoPop) begin
                overflow <= 1'b1;
            end else if (wrStatus && HWDATA[ST_OVF]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            irq       <= 1'b1;
            baudCnt   <= '0;
            shadowDiv <= DEFAULT_DIV;
            shiftReg  <= '0;
            bitIdx    <= '0;
        end else begin
            irq <= fifoEmpty && (state == IDLE);
            if (state != IDLE) begin
                baudCnt <= baudCnt - 16'd1;
            end
            if (fifoPop) begin
                shiftReg  <= fifoHead;
                shadowDiv <= baudDiv;
                baudCnt   <= baudDiv - 16'd1;
                state     <= START;
                tx        <= 1'b0;
            end else begin
                case (state)
                    START: if (bitDone) begin
                        state   <= DATA;
                        bitIdx  <= '0;
                        tx      <= shiftReg[0];
                        baudCnt <= shadowDiv - 16'd1;
                    end
                    DATA: if (bitDone) begin
                        baudCnt <= shadowDiv - 16'd1;
                        if (bitIdx == 3'(FRAME_BITS - 3)) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                            tx     <= shiftReg[bitIdx + 3'd1];
                        end
                    end
                    STOP: if (bitDone) begin
                        state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench: register vector table, frame-decoding scoreboard, timing corner cases
module tb_uart_tx_mmio;
    localparam logic [31:0] B = 32'h1001_0000;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    typedef struct {
        string       name;
        bit          doWr;
        logic [31:0] wAddr;
        logic [31:0] wData;
        bit          rdEn;
        logic [31:0] rAddr;
        logic [31:0] expRd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] HADDR = '0;
    logic [31:0] HWDATA = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] HRDATA;
    logic        tx;
    logic        irq;

    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;
    bit     monEn = 1'b0;
    frame_t expQ[$];
    int     startLog[$];
    vec_t   vecs[13];

    uart_tx_mmio dut (
        .clk      (clk),
        .rst      (rst),
        .HADDR    (HADDR),
        .HWDATA   (HWDATA),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .HRDATA   (HRDATA),
        .tx       (tx),
        .irq      (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        HADDR = addr;
        HWDATA = data;
        MemWrite = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic busRead(input logic [31:0] addr, input bit en, output logic [31:0] data);
        HADDR = addr;
        MemRead = en;
        #1;
        data = HRDATA;
        MemRead = 1'b0;
    endtask

    task automatic waitCyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [7:0] b, input int div, input bit expectTx);
        if (expectTx) expQ.push_back('{b, div});
        busWrite(B, {24'h0, b});
    endtask

    // Decode each frame at bit centres and compare against the scoreboard
    initial begin
        frame_t     e;
        logic [9:0] bits;
        int         off;
        forever begin
            @(negedge clk);
            if (monEn && tx === 1'b0) begin
                startLog.push_back(cyc);
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame at cycle %0d", cyc);
                    e = '{8'h00, 4};
                end else begin
                    e = expQ.pop_front();
                end
                off = 0;
                for (int k = 0; k < 10; k++) begin
                    while (off < k * e.div + e.div / 2) begin
                        @(negedge clk);
                        off++;
                    end
                    bits[k] = tx;
                end
                while (off < 10 * e.div - 1) begin
                    @(negedge clk);
                    off++;
                end
                check("frame_bits", {22'h0, bits}, {22'h0, 1'b1, e.data, 1'b0});
            end
        end
    end

    initial begin
        logic [31:0] rd;
        int          e0;
        int          busyBad;

        vecs[0]  = '{"rst_status",   0, B,         0,            1, B + 4,     32'h4};
        vecs[1]  = '{"rst_baud",     0, B,         0,            1, B + 8,     32'd434};
        vecs[2]  = '{"txdata_rd",    0, B,         0,            1, B,         32'h0};
        vecs[3]  = '{"rsvd_rd",      0, B,         0,            1, B + 32'hC, 32'h0};
        vecs[4]  = '{"baud_zero",    1, B + 8,     32'h0,        1, B + 8,     32'd2};
        vecs[5]  = '{"baud_one",     1, B + 8,     32'h1,        1, B + 8,     32'd2};
        vecs[6]  = '{"baud_trunc",   1, B + 8,     32'h0001_2345, 1, B + 8,    32'h2345};
        vecs[7]  = '{"rsvd_wr",      1, B + 32'hC, 32'h5,        1, B + 8,     32'h2345};
        vecs[8]  = '{"miss_wr",      1, B + 32'h28, 32'h7,       1, B + 8,     32'h2345};
        vecs[9]  = '{"miss_rd",      0, B,         0,            1, B + 32'h28, 32'h0};
        vecs[10] = '{"no_memread",   0, B,         0,            0, B + 8,     32'h0};
        vecs[11] = '{"low_bits",     1, B + 32'hA, 32'h4,        1, B + 9,     32'h4};
        vecs[12] = '{"ovf_clr_idle", 1, B + 4,     32'h8,        1, B + 4,     32'h4};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_irq", {31'h0, irq}, 32'h1);

        foreach (vecs[i]) begin
            if (vecs[i].doWr) busWrite(vecs[i].wAddr, vecs[i].wData);
            busRead(vecs[i].rAddr, vecs[i].rdEn, rd);
            check(vecs[i].name, rd, vecs[i].expRd);
        end

        // Single frame 0x55 at div 4
        monEn = 1'b1;
        startLog.delete();
        store(8'h55, 4, 1);
        e0 = cyc;
        check("tx_before_pop", {31'h0, tx}, 32'h1);
        busRead(B + 4, 1, rd);
        check("status_after_push", rd, 32'h10);
        waitCyc(e0 + 1);
        check("tx_start", {31'h0, tx}, 32'h0);
        busRead(B + 4, 1, rd);
        check("status_busy", rd, 32'h5);
        check("irq_busy", {31'h0, irq}, 32'h0);
        waitCyc(e0 + 40);
        busRead(B + 4, 1, rd);
        check("busy_last_cycle", rd, 32'h5);
        waitCyc(e0 + 41);
        busRead(B + 4, 1, rd);
        check("idle_after_frame", rd, 32'h4);
        check("irq_lag", {31'h0, irq}, 32'h0);
        waitCyc(e0 + 42);
        check("irq_back", {31'h0, irq}, 32'h1);
        check("start_latency", startLog.size() > 0 ? startLog[0] : -1, e0 + 1);

        // Back-to-back frames with no idle gap
        waitCyc(cyc + 5);
        startLog.delete();
        store(8'hA3, 4, 1);
        e0 = cyc;
        store(8'h0F, 4, 1);
        busyBad = 0;
        while (cyc < e0 + 80) begin
            busRead(B + 4, 1, rd);
            if (rd[0] !== 1'b1) busyBad++;
            @(posedge clk);
            #1;
        end
        check("busy_throughout", busyBad, 0);
        waitCyc(e0 + 85);
        check("b2b_gap", startLog.size() >= 2 ? startLog[1] - startLog[0] : -1, 40);

        // Fill and overflow at div 100
        busWrite(B + 8, 100);
        startLog.delete();
        store(8'h11, 100, 1);
        e0 = cyc;
        store(8'h22, 100, 1);
        store(8'h33, 100, 1);
        store(8'h44, 100, 1);
        store(8'h55, 100, 1);
        store(8'h66, 100, 0);
        busRead(B + 4, 1, rd);
        check("status_full_ovf", rd, 32'h4B);
        busWrite(B + 4, 32'h8);
        busRead(B + 4, 1, rd);
        check("ovf_cleared", rd, 32'h43);
        waitCyc(e0 + 5010);
        busRead(B + 4, 1, rd);
        check("drained", rd, 32'h4);
        check("five_frames", startLog.size(), 5);

        // Divisor change mid-frame applies to the next frame only
        busWrite(B + 8, 4);
        startLog.delete();
        store(8'h3C, 4, 1);
        e0 = cyc;
        waitCyc(e0 + 10);
        busWrite(B + 8, 8);
        store(8'hC5, 8, 1);
        waitCyc(e0 + 41 + 79);
        busRead(B + 4, 1, rd);
        check("div8_still_busy", rd, 32'h5);
        waitCyc(e0 + 41 + 80);
        busRead(B + 4, 1, rd);
        check("div8_done", rd, 32'h4);
        check("div_change_gap", startLog.size() >= 2 ? startLog[1] - startLog[0] : -1, 40);

        // Reset during DATA bit 3 (byte bit3 = 0 so tx is low there)
        waitCyc(cyc + 5);
        busWrite(B + 8, 4);
        monEn = 1'b0;
        store(8'hF0, 4, 0);
        e0 = cyc;
        waitCyc(e0 + 1 + 17);
        check("tx_mid_bit3", {31'h0, tx}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_tx", {31'h0, tx}, 32'h1);
        check("abort_irq", {31'h0, irq}, 32'h1);
        busRead(B + 4, 1, rd);
        check("abort_status", rd, 32'h4);
        monEn = 1'b1;
        busWrite(B + 32'h20, 32'h41);
        busRead(B + 32'h20, 1, rd);
        check("miss_hrdata", rd, 32'h0);
        busRead(B + 4, 1, rd);
        check("miss_no_push", rd, 32'h4);
        waitCyc(cyc + 20);
        check("line_idle", {31'h0, tx}, 32'h1);
        check("scoreboard_empty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
